// File: rtl/token_pkg.sv
// Shared definitions for the token window counter: FSM state encoding and default window size.
package token_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_WINDOW = 16;

endpackage

// File: rtl/token_hs_reg.sv
// Result register with valid/ready handshake and optional sticky overrun flag.
// Behaviour on a lost result depends on TOKEN_WINDOW_OVERRUN_EN.
module token_hs_reg #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic             overrun
);

  logic xfer;

  always_comb begin
    xfer = cnt_valid && cnt_ready;
  end

`ifdef TOKEN_WINDOW_OVERRUN_EN
  logic lost;

  // A result arriving while the previous one is still unread is dropped.
  always_comb begin
    lost = load && cnt_valid && !cnt_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (lost) begin
        overrun <= 1'b1;
      end else if (load) begin
        cnt_data  <= load_data;
        cnt_valid <= 1'b1;
      end else if (xfer) begin
        cnt_valid <= 1'b0;
      end
    end
  end
`else
  // A result arriving while the previous one is unread simply replaces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
    end else begin
      if (load) begin
        cnt_data  <= load_data;
        cnt_valid <= 1'b1;
      end else if (xfer) begin
        cnt_valid <= 1'b0;
      end
    end
  end

  assign overrun = 1'b0;
`endif

endmodule

// File: rtl/token_window_counter.sv
// Counts tokens on 'a' over windows of WINDOW enabled cycles and hands each count out via valid/ready.
// Optional macro TOKEN_WINDOW_OVERRUN_EN keeps the unread result and flags overrun instead of overwriting.
module token_window_counter
  import token_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             en,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic             overrun
);

  localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc;
  logic             close;
  logic [CNT_W-1:0] result;

  // idx and acc are zero in IDLE, so the same close test covers WINDOW=1.
  always_comb begin
    close  = en && (idx == LAST_IDX);
    result = acc + CNT_W'(a);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !close) begin
            state <= COUNT;
            idx   <= IDX_W'(1);
            acc   <= result;
          end
        end
        COUNT: begin
          if (en) begin
            if (close) begin
              state <= IDLE;
              idx   <= '0;
              acc   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
              acc <= result;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          acc   <= '0;
        end
      endcase
    end
  end

  token_hs_reg #(
    .CNT_W(CNT_W)
  ) u_hs_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (close),
    .load_data(result),
    .cnt_ready(cnt_ready),
    .cnt_data (cnt_data),
    .cnt_valid(cnt_valid),
    .overrun  (overrun)
  );

endmodule
